// File: rtl/zap_mem_arbiter.sv
// zap_mem_arbiter: shares one single-ported, variable-latency memory bus between ZAP fetch and load/store.
// Optional macro ZAP_ARB_STARVE_EN adds a fetch starvation guard (forced fetch after STARVE_LIMIT data grants).
module zap_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_d_rd_en,
  input  logic              i_d_wr_en,
  input  logic [ADDR_W-1:0] i_d_address,
  input  logic [31:0]       i_d_wdata,
  output logic              o_d_stall,
  output logic [31:0]       o_d_rdata,
  output logic              o_d_abort,
  input  logic              i_f_rd_en,
  input  logic [ADDR_W-1:0] i_f_address,
  input  logic              i_f_flush,
  output logic              o_f_valid,
  output logic [31:0]       o_f_instruction,
  output logic              o_f_abort,
  output logic              o_mem_rd_en,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_err
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  state_t state_reg;
  logic   d_done_reg;
  logic   f_done_reg;
  logic   flush_pending_reg;
  logic   d_req;
  logic   fetch_ok;
  logic   data_win;
  logic   fetch_win;
  logic   data_grant;
  logic   fetch_grant;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_range
    $error("zap_mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  assign d_req     = i_d_rd_en | i_d_wr_en;
  assign o_d_stall = d_req & ~d_done_reg;
  // The done flags keep a just-completed (stale) request from being granted again.
  assign fetch_ok  = i_f_rd_en & ~f_done_reg & ~i_f_flush;

`ifdef ZAP_ARB_STARVE_EN
  logic [3:0] starve_reg;
  logic       force_fetch;

  assign force_fetch = fetch_ok & (starve_reg == 4'(STARVE_LIMIT));
  assign data_win    = d_req & ~d_done_reg & ~force_fetch;
  assign fetch_win   = fetch_ok & (~d_req | force_fetch);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      starve_reg <= '0;
    end else if (!i_f_rd_en || fetch_grant) begin
      starve_reg <= '0;
    end else if (data_grant && starve_reg != 4'(STARVE_LIMIT)) begin
      starve_reg <= starve_reg + 4'd1;
    end
  end
`else
  assign data_win  = d_req & ~d_done_reg;
  assign fetch_win = fetch_ok & ~d_req;
`endif

  assign data_grant  = (state_reg == IDLE) & data_win;
  assign fetch_grant = (state_reg == IDLE) & ~data_win & fetch_win;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg         <= IDLE;
      d_done_reg        <= 1'b0;
      f_done_reg        <= 1'b0;
      flush_pending_reg <= 1'b0;
      o_mem_rd_en       <= 1'b0;
      o_mem_wr_en       <= 1'b0;
      o_mem_address     <= '0;
      o_mem_wdata       <= '0;
      o_d_rdata         <= '0;
      o_d_abort         <= 1'b0;
      o_f_valid         <= 1'b0;
      o_f_instruction   <= '0;
      o_f_abort         <= 1'b0;
    end else begin
      d_done_reg <= 1'b0;
      f_done_reg <= 1'b0;
      o_d_abort  <= 1'b0;
      o_f_valid  <= 1'b0;
      o_f_abort  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (data_grant) begin
            state_reg     <= DATA;
            o_mem_address <= i_d_address;
            o_mem_wdata   <= i_d_wdata;
            o_mem_wr_en   <= i_d_wr_en;
            o_mem_rd_en   <= ~i_d_wr_en;
          end else if (fetch_grant) begin
            state_reg     <= FETCH;
            o_mem_address <= i_f_address;
            o_mem_rd_en   <= 1'b1;
            o_mem_wr_en   <= 1'b0;
          end
        end
        DATA: begin
          if (i_mem_ready) begin
            state_reg   <= IDLE;
            o_mem_rd_en <= 1'b0;
            o_mem_wr_en <= 1'b0;
            if (o_mem_rd_en) begin
              o_d_rdata <= i_mem_rdata;
            end
            o_d_abort  <= i_mem_err;
            d_done_reg <= 1'b1;
          end
        end
        FETCH: begin
          // A flushed beat still runs to completion; only its result is suppressed.
          if (i_mem_ready) begin
            state_reg         <= IDLE;
            o_mem_rd_en       <= 1'b0;
            o_mem_wr_en       <= 1'b0;
            o_f_instruction   <= i_mem_rdata;
            o_f_abort         <= i_mem_err;
            o_f_valid         <= ~(flush_pending_reg | i_f_flush);
            f_done_reg        <= 1'b1;
            flush_pending_reg <= 1'b0;
          end else if (i_f_flush) begin
            flush_pending_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
